fetch_seq_ctrl: RTL and testbench

//  Fetch sequencer: owns the PC and drives the word-wide instruction-memory port. Handles
//  RV32C halfword alignment, holds leftover upper halves, and stitches 32-bit instructions

---
 rtl/fetch_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, drives the word-wide instruction-memory port and hands
// halfword-aligned RV32C/RV32I instructions (with their PC) to decode over valid/ready.
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    output logic        o_out_compressed
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    localparam logic [31:0] RST_PC = RESET_PC & ~32'd1;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [15:0] r_hbuf;
    logic [31:0] r_hbuf_addr;
    logic        r_hbuf_valid;
    logic        r_stitch;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_out_compressed;

    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_next;
    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic        w_hs;
    logic        w_hbuf_hit;
    logic        w_redir_drain;

    function automatic logic is_comp(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    assign w_redir_pc = i_redirect_pc & ~32'd1;
    assign w_hs       = r_out_valid & i_out_ready;
    assign w_pc_next  = r_pc + (r_out_compressed ? 32'd2 : 32'd4);
    assign w_hbuf_hit = r_hbuf_valid && (w_pc_next == r_hbuf_addr);
    assign w_lo       = i_imem_rdata[15:0];
    assign w_hi       = i_imem_rdata[31:16];
    // A granted read whose rvalid has not yet appeared must be swallowed after a redirect.
    assign w_redir_drain = (r_state == S_REQ && i_imem_gnt) ||
                           ((r_state == S_WAIT || r_state == S_DRAIN) && !i_imem_rvalid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_pc             <= RST_PC;
            r_hbuf           <= '0;
            r_hbuf_addr      <= '0;
            r_hbuf_valid     <= 1'b0;
            r_stitch         <= 1'b0;
            r_imem_req       <= 1'b0;
            r_imem_addr      <= '0;
            r_out_valid      <= 1'b0;
            r_out_instr      <= '0;
            r_out_pc         <= '0;
            r_out_compressed <= 1'b0;
        end else if (i_redirect_valid) begin
            r_pc         <= w_redir_pc;
            r_hbuf_valid <= 1'b0;
            r_stitch     <= 1'b0;
            r_out_valid  <= 1'b0;
            if (w_redir_drain) begin
                r_state    <= S_DRAIN;
                r_imem_req <= 1'b0;
            end else begin
                r_state     <= S_REQ;
                r_imem_req  <= 1'b1;
                r_imem_addr <= word_of(w_redir_pc);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= word_of(r_pc);
                end
                S_REQ: begin
                    if (i_imem_gnt) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_stitch) begin
                            // Second word of a straddling instruction; its upper half is the next one.
                            r_out_valid      <= 1'b1;
                            r_out_instr      <= {w_lo, r_hbuf};
                            r_out_pc         <= r_pc;
                            r_out_compressed <= 1'b0;
                            r_hbuf           <= w_hi;
                            r_hbuf_addr      <= r_pc + 32'd4;
                            r_hbuf_valid     <= 1'b1;
                            r_stitch         <= 1'b0;
                            r_state          <= S_HOLD;
                        end else if (!r_pc[1]) begin
                            r_out_valid <= 1'b1;
                            r_out_pc    <= r_pc;
                            r_state     <= S_HOLD;
                            if (is_comp(w_lo)) begin
                                r_out_instr      <= {16'h0000, w_lo};
                                r_out_compressed <= 1'b1;
                                r_hbuf           <= w_hi;
                                r_hbuf_addr      <= r_pc + 32'd2;
                                r_hbuf_valid     <= 1'b1;
                            end else begin
                                r_out_instr      <= i_imem_rdata;
                                r_out_compressed <= 1'b0;
                                r_hbuf_valid     <= 1'b0;
                            end
                        end else if (is_comp(w_hi)) begin
                            r_out_valid      <= 1'b1;
                            r_out_instr      <= {16'h0000, w_hi};
                            r_out_pc         <= r_pc;
                            r_out_compressed <= 1'b1;
                            r_hbuf_valid     <= 1'b0;
                            r_state          <= S_HOLD;
                        end else begin
                            r_hbuf       <= w_hi;
                            r_hbuf_valid <= 1'b0;
                            r_stitch     <= 1'b1;
                            r_state      <= S_REQ;
                            r_imem_req   <= 1'b1;
                            r_imem_addr  <= word_of(r_pc) + 32'd4;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_hs) begin
                        r_pc         <= w_pc_next;
                        r_hbuf_valid <= 1'b0;
                        if (w_hbuf_hit && is_comp(r_hbuf)) begin
                            r_out_instr      <= {16'h0000, r_hbuf};
                            r_out_pc         <= w_pc_next;
                            r_out_compressed <= 1'b1;
                        end else if (w_hbuf_hit) begin
                            r_out_valid <= 1'b0;
                            r_stitch    <= 1'b1;
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= word_of(w_pc_next) + 32'd4;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= word_of(w_pc_next);
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_imem_rvalid) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= word_of(r_pc);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req       = r_imem_req;
    assign o_imem_addr      = r_imem_addr;
    assign o_out_valid      = r_out_valid;
    assign o_out_instr      = r_out_instr;
    assign o_out_pc         = r_out_pc;
    assign o_out_compressed = r_out_compressed;
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios plus a randomized run, with a memory
// responder and an instruction-stream reference model derived from the memory image.
module tb_fetch_seq_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_instr;
    logic [31:0] o_out_pc;
    logic        o_out_compressed;

    fetch_seq_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_gnt       (i_imem_gnt),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_out_instr      (o_out_instr),
        .o_out_pc         (o_out_pc),
        .o_out_compressed (o_out_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          checks = 0;
    int          failures = 0;
    logic        mem_pend = 1'b0;
    logic        mem_hold = 1'b0;
    logic [31:0] mem_pend_addr = '0;
    int          mem_lat = 0;
    int          gnt_wait = 0;
    int          fix_lat = 0;
    logic        rnd_lat = 1'b0;
    int          rdy_pct = 100;
    logic        redir_now = 1'b0;
    logic [31:0] redir_target = '0;
    logic [31:0] exp_pc = '0;
    int          gnt_cnt = 0;
    int          hs_cnt = 0;
    int          req_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Halfword at a byte address; the memory image is 1 KiB, aliased over the address space.
    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic tick();
        logic        pend0, rv, gn, hs, st, rw, rd, s_comp, e_comp;
        logic [31:0] s_instr, s_pc, s_addr, e_instr;
        logic [15:0] h0;
        pend0 = mem_pend;
        rv = 1'b0;
        if (mem_pend && !mem_hold) begin
            if (mem_lat == 0) rv = 1'b1;
            else mem_lat--;
        end
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? mem[mem_pend_addr[9:2]] : $urandom();
        if (rv) mem_pend = 1'b0;
        gn = 1'b0;
        if (o_imem_req) begin
            chk("addr_align", {30'b0, o_imem_addr[1:0]}, 32'd0);
            chk("one_outstanding", {31'b0, pend0}, 32'd0);
            if (!pend0) begin
                if (gnt_wait == 0) begin
                    gn = 1'b1;
                    mem_pend = 1'b1;
                    mem_pend_addr = o_imem_addr;
                    mem_lat = rnd_lat ? int'($urandom_range(0, 2)) : fix_lat;
                    gnt_wait = rnd_lat ? int'($urandom_range(0, 2)) : 0;
                    gnt_cnt++;
                end else begin
                    gnt_wait--;
                end
            end
            req_cycles++;
        end
        i_imem_gnt = gn;
        i_out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        i_redirect_valid = redir_now;
        i_redirect_pc = redir_now ? redir_target : $urandom();
        hs = o_out_valid && i_out_ready;
        if (hs) begin
            h0 = half_at(exp_pc);
            e_comp = (h0[1:0] != 2'b11);
            e_instr = e_comp ? {16'h0000, h0} : {half_at(exp_pc + 32'd2), h0};
            chk("hs_instr", o_out_instr, e_instr);
            chk("hs_pc", o_out_pc, exp_pc);
            chk("hs_comp", {31'b0, o_out_compressed}, {31'b0, e_comp});
            exp_pc = exp_pc + (e_comp ? 32'd2 : 32'd4);
            hs_cnt++;
        end
        if (redir_now) exp_pc = redir_target & ~32'd1;
        st = o_out_valid && !i_out_ready && !redir_now;
        rw = o_imem_req && !gn && !redir_now;
        rd = redir_now;
        s_instr = o_out_instr;
        s_pc = o_out_pc;
        s_comp = o_out_compressed;
        s_addr = o_imem_addr;
        redir_now = 1'b0;
        @(posedge clk);
        #1;
        if (st) begin
            chk("stall_valid", {31'b0, o_out_valid}, 32'd1);
            chk("stall_instr", o_out_instr, s_instr);
            chk("stall_pc", o_out_pc, s_pc);
            chk("stall_comp", {31'b0, o_out_compressed}, {31'b0, s_comp});
            chk("stall_noreq", {31'b0, o_imem_req}, 32'd0);
        end
        if (rw) begin
            chk("req_held", {31'b0, o_imem_req}, 32'd1);
            chk("req_addr_held", o_imem_addr, s_addr);
        end
        if (rd) chk("redirect_flush", {31'b0, o_out_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_pend = 1'b0;
        mem_hold = 1'b0;
        gnt_wait = 0;
        gnt_cnt = 0;
        redir_now = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_req", {31'b0, o_imem_req}, 32'd0);
        chk("rst_addr", o_imem_addr, 32'd0);
        chk("rst_valid", {31'b0, o_out_valid}, 32'd0);
        chk("rst_instr", o_out_instr, 32'd0);
        chk("rst_pc", o_out_pc, 32'd0);
        chk("rst_comp", {31'b0, o_out_compressed}, 32'd0);
        reset_n = 1'b1;
        exp_pc = RESET_PC;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!o_out_valid && k < 100) begin tick(); k++; end
        chk(tag, {31'b0, o_out_valid}, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!o_imem_req && k < 100) begin tick(); k++; end
        chk(tag, {31'b0, o_imem_req}, 32'd1);
    endtask

    task automatic wait_pend(input string tag);
        int k = 0;
        while (!mem_pend && k < 100) begin tick(); k++; end
        chk(tag, {31'b0, mem_pend}, 32'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    endtask

    initial begin
        int rc, h;
        logic [31:0] w;
        logic [15:0] hw;
        reset_n = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc = '0;
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = '0;
        i_out_ready = 1'b0;

        // Aligned 32-bit instruction
        clear_mem();
        mem[0] = 32'h00A0_0093;
        do_reset();
        tick();
        chk("t1_first_req", {31'b0, o_imem_req}, 32'd1);
        chk("t1_first_addr", o_imem_addr, 32'h0);
        wait_valid("t1_valid");
        chk("t1_instr", o_out_instr, 32'h00A0_0093);
        chk("t1_pc", o_out_pc, 32'h0);
        chk("t1_comp", {31'b0, o_out_compressed}, 32'd0);
        tick();
        wait_req("t1_req2");
        chk("t1_next_addr", o_imem_addr, 32'h4);

        // Two compressed instructions from one word, second from the half buffer
        clear_mem();
        mem[0] = 32'h4505_4501;
        do_reset();
        wait_valid("t2_valid1");
        chk("t2_instr1", o_out_instr, 32'h0000_4501);
        chk("t2_pc1", o_out_pc, 32'h0);
        chk("t2_comp1", {31'b0, o_out_compressed}, 32'd1);
        rc = req_cycles;
        tick();
        chk("t2_valid2", {31'b0, o_out_valid}, 32'd1);
        chk("t2_instr2", o_out_instr, 32'h0000_4505);
        chk("t2_pc2", o_out_pc, 32'h2);
        tick();
        chk("t2_no_req_between", req_cycles, rc);
        wait_req("t2_req");
        chk("t2_next_addr", o_imem_addr, 32'h4);

        // 32-bit instruction straddling a word boundary
        clear_mem();
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h4505_00A0;
        do_reset();
        wait_valid("t3_valid1");
        chk("t3_instr1", o_out_instr, 32'h0000_4501);
        tick();
        wait_valid("t3_valid2");
        chk("t3_instr2", o_out_instr, 32'h00A0_0093);
        chk("t3_pc2", o_out_pc, 32'h2);
        chk("t3_comp2", {31'b0, o_out_compressed}, 32'd0);
        chk("t3_fetches2", gnt_cnt, 32'd2);
        tick();
        wait_valid("t3_valid3");
        chk("t3_instr3", o_out_instr, 32'h0000_4505);
        chk("t3_pc3", o_out_pc, 32'h6);
        chk("t3_fetches3", gnt_cnt, 32'd2);
        tick();

        // Redirect while a read is outstanding
        clear_mem();
        mem[0] = 32'h00A0_0093;
        mem[64] = 32'h4505_0001;
        fix_lat = 2;
        do_reset();
        wait_pend("t4_granted");
        redir_now = 1'b1;
        redir_target = 32'h0000_0102;
        tick();
        wait_req("t4_req");
        chk("t4_addr", o_imem_addr, 32'h100);
        wait_valid("t4_valid");
        chk("t4_instr", o_out_instr, 32'h0000_4505);
        chk("t4_pc", o_out_pc, 32'h102);
        chk("t4_comp", {31'b0, o_out_compressed}, 32'd1);
        tick();

        // Consumer back-pressure
        clear_mem();
        mem[0] = 32'h00A0_0093;
        fix_lat = 0;
        rdy_pct = 0;
        do_reset();
        wait_valid("t5_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", {31'b0, o_out_valid}, 32'd1);
            chk("t5_hold_instr", o_out_instr, 32'h00A0_0093);
            chk("t5_hold_noreq", {31'b0, o_imem_req}, 32'd0);
        end
        rdy_pct = 100;
        h = hs_cnt;
        tick();
        chk("t5_one_hs", hs_cnt, h + 1);
        chk("t5_valid_drop", {31'b0, o_out_valid}, 32'd0);

        // Asynchronous reset during WAIT, then a late rvalid while IDLE
        clear_mem();
        mem[0] = 32'h00A0_0093;
        mem[128] = 32'h4505_4505;
        fix_lat = 3;
        do_reset();
        wait_valid("t6_valid0");
        tick();
        wait_pend("t6_granted");
        tick();
        mem_hold = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("t6_async_req", {31'b0, o_imem_req}, 32'd0);
        chk("t6_async_addr", o_imem_addr, 32'd0);
        chk("t6_async_valid", {31'b0, o_out_valid}, 32'd0);
        chk("t6_async_instr", o_out_instr, 32'd0);
        chk("t6_async_pc", o_out_pc, 32'd0);
        chk("t6_async_comp", {31'b0, o_out_compressed}, 32'd0);
        tick();
        tick();
        mem_pend_addr = 32'h200;
        mem_lat = 0;
        mem_hold = 1'b0;
        reset_n = 1'b1;
        exp_pc = RESET_PC;
        tick();
        chk("t6_late_ignored", {31'b0, o_out_valid}, 32'd0);
        chk("t6_req", {31'b0, o_imem_req}, 32'd1);
        chk("t6_addr", o_imem_addr, RESET_PC);
        wait_valid("t6_valid");
        chk("t6_instr", o_out_instr, 32'h00A0_0093);
        chk("t6_pc", o_out_pc, RESET_PC);
        tick();

        // Randomized run: mixed halfword widths, random latency, stalls and redirects
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                hw = 16'($urandom());
                if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
                else if (hw[1:0] == 2'b11) hw[1:0] = 2'b01;
                w[k*16 +: 16] = hw;
            end
            mem[i] = w;
        end
        rnd_lat = 1'b1;
        rdy_pct = 70;
        do_reset();
        h = hs_cnt;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 4) begin
                redir_now = 1'b1;
                redir_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                            : ($urandom() & 32'h0000_03FF);
            end
            tick();
        end
        chk("rnd_progress", {31'b0, (hs_cnt - h) >= 300}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
